// File: rtl/brick_field_pkg.sv
// Shared constants and FSM state type for the brick grid.
package brick_field_pkg;

  localparam int unsigned GRID_COLS    = 10;
  localparam int unsigned GRID_ROWS    = 6;
  localparam int unsigned BRICK_W_LOG2 = 6;
  localparam int unsigned BRICK_H_LOG2 = 4;
  localparam int unsigned NUM_BRICKS   = GRID_COLS * GRID_ROWS;

  typedef enum logic [1:0] {
    StPlay    = 2'd0,
    StLockout = 2'd1,
    StCleared = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_inc4.sv
// Four-digit BCD incrementer that saturates at 9999.
module bcd_inc4 (
  input  logic [15:0] bcd_i,
  output logic [15:0] bcd_o
);

  logic carry;

  always_comb begin
    bcd_o = bcd_i;
    carry = 1'b1;
    if (bcd_i != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (bcd_i[4*i +: 4] == 4'd9) begin
            bcd_o[4*i +: 4] = 4'd0;
          end else begin
            bcd_o[4*i +: 4] = bcd_i[4*i +: 4] + 4'd1;
            carry           = 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/brick_field.sv
// Brick grid state, ball collision detection, hit lockout and BCD score.
module brick_field
  import brick_field_pkg::*;
#(
  parameter int unsigned BRICK_Y0    = 32,
  parameter int unsigned LOCK_FRAMES = 3
) (
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic        refill,
  input  logic [9:0]  BallX,
  input  logic [9:0]  BallY,
  input  logic        Ball_out,
  output logic [59:0] brick_alive,
  output logic        hit,
  output logic [2:0]  hit_row,
  output logic [3:0]  hit_col,
  output logic [15:0] score,
  output logic        all_clear
);

  localparam logic [9:0] YTop = 10'(BRICK_Y0);
  localparam logic [9:0] YEnd = 10'(BRICK_Y0 + GRID_ROWS * (1 << BRICK_H_LOG2));
  localparam logic [9:0] XMax = 10'(GRID_COLS * (1 << BRICK_W_LOG2) - 1);
  localparam int unsigned CntW = (LOCK_FRAMES > 1) ? $clog2(LOCK_FRAMES) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(LOCK_FRAMES - 1);

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic [NUM_BRICKS-1:0] alive_q;
  logic                hit_q;
  logic [2:0]          hit_row_q;
  logic [3:0]          hit_col_q;
  logic [15:0]         score_q;
  logic [15:0]         score_d;
  logic                all_clear_q;

  logic [9:0] y_off;
  logic       in_grid;
  logic [2:0] probe_row;
  logic [3:0] probe_col;
  logic [5:0] probe_idx;
  logic       probe_hit;

  always_comb begin
    in_grid   = (BallX <= XMax) && (BallY >= YTop) && (BallY < YEnd);
    y_off     = BallY - YTop;
    probe_row = 3'(y_off >> BRICK_H_LOG2);
    probe_col = 4'(BallX >> BRICK_W_LOG2);
    probe_idx = 6'(probe_row) * 6'(GRID_COLS) + 6'(probe_col);
    probe_hit = in_grid && !Ball_out && alive_q[probe_idx];
  end

  bcd_inc4 u_bcd_inc4 (
    .bcd_i (score_q),
    .bcd_o (score_d)
  );

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= StPlay;
      cnt_q       <= '0;
      alive_q     <= '1;
      hit_q       <= 1'b0;
      hit_row_q   <= '0;
      hit_col_q   <= '0;
      score_q     <= '0;
      all_clear_q <= 1'b0;
    end else begin
      hit_q <= 1'b0;
      // Refill overrides any hit sampled on the same edge.
      if (refill) begin
        alive_q     <= '1;
        all_clear_q <= 1'b0;
        state_q     <= StPlay;
        cnt_q       <= '0;
      end else begin
        unique case (state_q)
          StPlay: begin
            if (probe_hit) begin
              alive_q[probe_idx] <= 1'b0;
              hit_q              <= 1'b1;
              hit_row_q          <= probe_row;
              hit_col_q          <= probe_col;
              score_q            <= score_d;
              state_q            <= StLockout;
              cnt_q              <= '0;
            end
          end
          StLockout: begin
            if (cnt_q == LastCnt) begin
              cnt_q <= '0;
              if (alive_q == '0) begin
                state_q     <= StCleared;
                all_clear_q <= 1'b1;
              end else begin
                state_q <= StPlay;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          StCleared: all_clear_q <= 1'b1;
          default:   state_q     <= StPlay;
        endcase
      end
    end
  end

  assign brick_alive = alive_q;
  assign hit         = hit_q;
  assign hit_row     = hit_row_q;
  assign hit_col     = hit_col_q;
  assign score       = score_q;
  assign all_clear   = all_clear_q;

endmodule

// File: tb/tb_brick_field.sv
// Directed bench for brick_field: collisions, lockout, grid edges, clear/refill, score saturation.
module tb_brick_field;

  localparam int unsigned LockFrames = 3;
  localparam logic [59:0] AllOnes = {60{1'b1}};

  logic        Reset;
  logic        frame_clk;
  logic        refill;
  logic [9:0]  BallX;
  logic [9:0]  BallY;
  logic        Ball_out;
  logic [59:0] brick_alive;
  logic        hit;
  logic [2:0]  hit_row;
  logic [3:0]  hit_col;
  logic [15:0] score;
  logic        all_clear;

  int errors = 0;
  int checks = 0;
  int n_score = 0;
  int hits;
  int idx;

  brick_field #(
    .BRICK_Y0    (32),
    .LOCK_FRAMES (LockFrames)
  ) dut (
    .Reset       (Reset),
    .frame_clk   (frame_clk),
    .refill      (refill),
    .BallX       (BallX),
    .BallY       (BallY),
    .Ball_out    (Ball_out),
    .brick_alive (brick_alive),
    .hit         (hit),
    .hit_row     (hit_row),
    .hit_col     (hit_col),
    .score       (score),
    .all_clear   (all_clear)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge frame_clk);
    #1;
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // Strike brick i at its centre, check the pulse, then sit out the lockout off-grid.
  task automatic hit_brick(input int i);
    int r;
    int c;
    r = i / 10;
    c = i % 10;
    BallX = 10'(c * 64 + 32);
    BallY = 10'(32 + r * 16 + 8);
    step();
    n_score = (n_score < 9999) ? n_score + 1 : 9999;
    chk("run_hit", 64'(hit), 64'd1);
    chk("run_row", 64'(hit_row), 64'(r));
    chk("run_col", 64'(hit_col), 64'(c));
    chk("run_bit", 64'(brick_alive[i]), 64'd0);
    chk("run_score", 64'(score), 64'(to_bcd(n_score)));
    BallY = 10'd0;
    repeat (LockFrames) step();
  endtask

  initial begin
    Reset    = 1'b1;
    refill   = 1'b0;
    BallX    = 10'd0;
    BallY    = 10'd0;
    Ball_out = 1'b0;
    #12;
    chk("rst_alive", 64'(brick_alive), 64'(AllOnes));
    chk("rst_hit", 64'(hit), 64'd0);
    chk("rst_row", 64'(hit_row), 64'd0);
    chk("rst_col", 64'(hit_col), 64'd0);
    chk("rst_score", 64'(score), 64'h0);
    chk("rst_clear", 64'(all_clear), 64'd0);
    Reset = 1'b0;

    // First hit and held probe.
    BallX = 10'd100;
    BallY = 10'd40;
    step();
    chk("h1_hit", 64'(hit), 64'd1);
    chk("h1_row", 64'(hit_row), 64'd0);
    chk("h1_col", 64'(hit_col), 64'd1);
    chk("h1_bit1", 64'(brick_alive[1]), 64'd0);
    chk("h1_score", 64'(score), 64'h0001);
    hits = 0;
    repeat (4) begin
      step();
      if (hit) hits++;
    end
    chk("hold_extra_hits", 64'(hits), 64'd0);
    chk("hold_score", 64'(score), 64'h0001);

    // Bottom-right corner brick.
    BallX = 10'd639;
    BallY = 10'd127;
    step();
    chk("br_hit", 64'(hit), 64'd1);
    chk("br_row", 64'(hit_row), 64'd5);
    chk("br_col", 64'(hit_col), 64'd9);
    chk("br_bit59", 64'(brick_alive[59]), 64'd0);
    chk("br_score", 64'(score), 64'h0002);
    BallY = 10'd0;
    repeat (LockFrames) step();
    chk("row_hold", 64'(hit_row), 64'd5);
    chk("col_hold", 64'(hit_col), 64'd9);

    // Just below and above the grid.
    hits  = 0;
    BallX = 10'd600;
    BallY = 10'd128;
    repeat (2) begin
      step();
      if (hit) hits++;
    end
    BallX = 10'd0;
    BallY = 10'd31;
    repeat (2) begin
      step();
      if (hit) hits++;
    end
    chk("edge_y_no_hit", 64'(hits), 64'd0);

    // Ball lost suppresses detection.
    hits     = 0;
    BallY    = 10'd32;
    Ball_out = 1'b1;
    repeat (2) begin
      step();
      if (hit) hits++;
    end
    chk("ballout_no_hit", 64'(hits), 64'd0);
    chk("ballout_bit0", 64'(brick_alive[0]), 64'd1);
    Ball_out = 1'b0;

    // Refill coinciding with a valid probe.
    refill = 1'b1;
    step();
    refill = 1'b0;
    chk("refill_hit", 64'(hit), 64'd0);
    chk("refill_alive", 64'(brick_alive), 64'(AllOnes));
    chk("refill_score", 64'(score), 64'h0002);
    BallY = 10'd0;

    // Asynchronous reset mid-cycle, then clear the whole field.
    #2 Reset = 1'b1;
    #2 Reset = 1'b0;
    chk("rst2_score", 64'(score), 64'h0);
    n_score = 0;
    for (int i = 0; i < 60; i++) hit_brick(i);
    chk("clr_score", 64'(score), 64'h0060);
    chk("clr_flag", 64'(all_clear), 64'd1);
    chk("clr_alive", 64'(brick_alive), 64'd0);
    hits  = 0;
    BallX = 10'd100;
    BallY = 10'd40;
    repeat (3) begin
      step();
      if (hit) hits++;
    end
    chk("clr_ignore", 64'(hits), 64'd0);
    chk("clr_hold", 64'(all_clear), 64'd1);
    refill = 1'b1;
    step();
    refill = 1'b0;
    chk("rf_clear", 64'(all_clear), 64'd0);
    chk("rf_alive", 64'(brick_alive), 64'(AllOnes));
    chk("rf_score", 64'(score), 64'h0060);

    // Run the score to saturation.
    idx = 0;
    while (n_score < 9999) begin
      hit_brick(idx);
      idx++;
      if (idx == 60) begin
        idx    = 0;
        refill = 1'b1;
        step();
        refill = 1'b0;
      end
    end
    chk("sat_reach", 64'(score), 64'h9999);
    hit_brick(idx);
    chk("sat_hold", 64'(score), 64'h9999);

    // Reset asserted during lockout.
    refill = 1'b1;
    step();
    refill = 1'b0;
    BallX = 10'd32;
    BallY = 10'd40;
    step();
    chk("lk_hit", 64'(hit), 64'd1);
    step();
    #2 Reset = 1'b1;
    #1;
    chk("lkrst_alive", 64'(brick_alive), 64'(AllOnes));
    chk("lkrst_hit", 64'(hit), 64'd0);
    chk("lkrst_row", 64'(hit_row), 64'd0);
    chk("lkrst_col", 64'(hit_col), 64'd0);
    chk("lkrst_score", 64'(score), 64'h0);
    chk("lkrst_clear", 64'(all_clear), 64'd0);
    #1 Reset = 1'b0;
    step();
    chk("post_rst_hit", 64'(hit), 64'd1);
    chk("post_rst_score", 64'(score), 64'h0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/brick_field.md
BRICK_FIELD -- requirements
Module: brick_field

Interface
REQ-001 Parameter BRICK_Y0, default 32: top pixel row of the brick grid.
REQ-002 Parameter LOCK_FRAMES, default 3: hit lockout length in frame_clk cycles.
REQ-003 Reset  input  1  asynchronous, active-high.
REQ-004 frame_clk  input  1  clock; one rising edge per video frame.
REQ-005 refill  input  1  synchronous request to restore all bricks.
REQ-006 BallX  input  10  ball centre X from the ball stage.
REQ-007 BallY  input  10  ball centre Y from the ball stage.
REQ-008 Ball_out  input  1  ball lost; suppresses detection.
REQ-009 brick_alive  output  60  bit r*10+c set when the brick at row r, column c exists.
REQ-010 hit  output  1  one-cycle pulse per destroyed brick; also the Y-bounce request to the ball stage.
REQ-011 hit_row  output  3  row of the last destroyed brick.
REQ-012 hit_col  output  4  column of the last destroyed brick.
REQ-013 score  output  16  four BCD digits, [15:12] most significant.
REQ-014 all_clear  output  1  high while no bricks remain.

Function
REQ-015 Grid SHALL be 10 columns x 6 rows; bricks 64 px wide x 16 px high; column 0 starts at X=0; row 0 starts at Y=BRICK_Y0.
REQ-016 Probe point SHALL be (BallX, BallY); col = BallX[9:6]; row = (BallY-BRICK_Y0)>>4.
REQ-017 Probe SHALL be in-grid only when BallX<=639, BallY>=BRICK_Y0 and BallY<BRICK_Y0+96; otherwise no hit.
REQ-018 FSM states SHALL be PLAY, LOCKOUT and CLEARED.
REQ-019 PLAY: if the probe is in-grid, the addressed bit is set and Ball_out=0, then on the next edge the FSM SHALL clear the bit, assert hit for one cycle, load hit_row/hit_col, add 1 to score and enter LOCKOUT.
REQ-020 LOCKOUT SHALL ignore all probes for LOCK_FRAMES cycles, then enter PLAY; if brick_alive==0, it SHALL enter CLEARED instead.
REQ-021 CLEARED SHALL assert all_clear, ignore probes and hold until refill.
REQ-022 refill=1 in any state SHALL set all 60 bits, deassert all_clear and enter PLAY on the next edge; score is unchanged.
REQ-023 refill coinciding with a valid hit: refill SHALL win; no hit, no clear, no score change.
REQ-024 Score SHALL increment in BCD with digit carry (0009->0010, 0099->0100) and saturate at 9999.
REQ-025 hit_row/hit_col SHALL hold their values until the next hit.
REQ-026 Latency from a sampled probe to hit SHALL be exactly one frame_clk edge; hit is registered.
REQ-027 At most one brick SHALL be destroyed per cycle.

Reset
REQ-028 Reset high SHALL force brick_alive all ones, hit=0, hit_row=0, hit_col=0, score=0000, all_clear=0 and state PLAY, independent of frame_clk.
REQ-029 Reset deasserted mid-LOCKOUT SHALL leave the block in PLAY with the lockout counter at 0.

Structure
REQ-030 Shared package SHALL hold GRID_COLS=10, GRID_ROWS=6, BRICK_W_LOG2=6, BRICK_H_LOG2=4 and the FSM state enum.
REQ-031 The BCD saturating incrementer SHALL be one sub-module, bcd_inc4.
REQ-032 All other logic SHALL be a single always_ff plus combinational index decode.

Verification
REQ-033 Reset, then BallX=100, BallY=40 -> next edge: hit=1, hit_row=0, hit_col=1, bit1=0, score=0001.
REQ-034 Hold the same probe for 5 cycles -> exactly one hit pulse; a second probe on bit1 after the lockout -> no hit, since the brick is already gone.
REQ-035 BallX=639, BallY=127 -> hit_row=5, hit_col=9, bit59=0; BallY=128 or BallY=31 -> no hit.
REQ-036 Destroy all 60 bricks -> score=0060, all_clear=1 after the last lockout; probes are ignored; refill -> all_clear=0, all bits set, score stays 0060.
REQ-037 refill and a valid probe in the same cycle -> no hit, brick_alive all ones; Ball_out=1 with a valid probe -> no hit.
REQ-038 Preload score 9999 and hit a brick -> score stays 9999; assert Reset mid-LOCKOUT -> all outputs at reset values immediately.
